// File: rtl/peri_master_if.sv
// Peripheral bus bundle between an initiator and a responder: level strobes
// regw/regr with address and write data out, one-cycle ack and read data back.
interface peri_master_if;
    logic        regw;
    logic        regr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdat;

    modport master (
        output regw, regr, adr, wdata,
        input  ack, rdat
    );

    modport slave (
        input  regw, regr, adr, wdata,
        output ack, rdat
    );
endinterface

// File: rtl/peri_master.sv
// Initiator for the regw/regr peripheral bus: one CPU load/store at a time.
// Optional REQ timeout abort is built when PERI_MST_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a CPU request; strobes low
//   REQ   | strobe held, waiting for ack (or timeout)
//   GAP   | one cycle with strobes low so the next strobe is a fresh edge
module peri_master #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_adr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_done,
    output logic          cpu_err,
    output logic [31:0]   cpu_rdata,
    peri_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_timeout
        $error("peri_master: TIMEOUT does not fit the TO_W counter");
    end

    state_t      state_q, state_d;
    logic        regw_q, regw_d;
    logic        regr_q, regr_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef PERI_MST_TIMEOUT_EN
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            regw_q  <= 1'b0;
            regr_q  <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
`ifdef PERI_MST_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            regw_q  <= regw_d;
            regr_q  <= regr_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef PERI_MST_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        regw_d  = regw_q;
        regr_d  = regr_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
`ifdef PERI_MST_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    adr_d   = cpu_adr;
                    wdata_d = cpu_wdata;
                    regw_d  = cpu_we;
                    regr_d  = !cpu_we;
`ifdef PERI_MST_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
`ifdef PERI_MST_TIMEOUT_EN
                cnt_d = cnt_q + TO_W'(1);
`endif
                // ack takes priority over an expiry landing on the same cycle
                if (bus.ack) begin
                    regw_d  = 1'b0;
                    regr_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef PERI_MST_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    if (regr_q) begin
                        rdata_d = bus.rdat;
                    end
                    state_d = GAP;
                end
`ifdef PERI_MST_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    regw_d  = 1'b0;
                    regr_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (regr_q) begin
                        rdata_d = '0;
                    end
                    state_d = GAP;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_ready = (state_q == IDLE);
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
`ifdef PERI_MST_TIMEOUT_EN
    assign cpu_err   = err_q;
`else
    assign cpu_err   = 1'b0;
`endif

    assign bus.regw  = regw_q;
    assign bus.regr  = regr_q;
    assign bus.adr   = adr_q;
    assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_peri_master.sv
// Directed bench for peri_master paired with a responder that acks four
// cycles into a strobe (strobe seen high at edges 1..5 after accept at edge 0).
module tb_peri_master;

    logic        clk;
    logic        rstz;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    peri_master_if bus ();

    peri_master #(.TIMEOUT(16), .TO_W(8)) dut (
        .clk       (clk),
        .rstz      (rstz),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // responder model
    logic       resp_en;
    logic       resp_ack;
    logic       force_ack;
    logic [2:0] dly;

    always @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            resp_ack <= 1'b0;
            dly      <= '0;
        end else if (resp_ack) begin
            resp_ack <= 1'b0;
            dly      <= '0;
        end else if (resp_en && (bus.regw || bus.regr)) begin
            dly <= dly + 3'd1;
            if (dly == 3'd3) begin
                resp_ack <= 1'b1;
                if (bus.regw) $display("responder write: %c", bus.wdata[7:0]);
            end
        end
    end

    assign bus.ack  = resp_ack | force_ack;
    assign bus.rdat = (bus.adr == 32'h0000_0100) ? 32'h1234_5678 : {bus.adr[15:0], 16'hBEEF};

    int both_cnt = 0;
    always @(negedge clk) if (bus.regw && bus.regr) both_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // per-transaction observations, edge numbers relative to the accept edge 0
    int          ack_at;
    int          pulse_at;
    int          t_len, t_done, t_ready, t_ndone, t_bad;
    logic [31:0] t_rdata;
    logic        t_err;

    task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input int limit);
        int c;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_adr = a; cpu_wdata = d;
        t_len = 0; t_done = -1; t_ready = -1; t_ndone = 0; t_bad = 0;
        t_rdata = '0; t_err = 1'b0; c = 0;
        while (t_ready < 0 && c < limit) begin
            @(negedge clk);
            c++;
            if (pulse_at == c - 1) begin
                cpu_req = 1'b1; cpu_we = !we; cpu_adr = 32'hDEAD_0000;
            end else begin
                cpu_req = 1'b0;
            end
            force_ack = (ack_at == c - 1);
            if (bus.regw || bus.regr) begin
                t_len++;
                if (bus.adr !== a || bus.regw !== we || (we && bus.wdata !== d)) t_bad++;
            end
            if (cpu_done) begin
                t_ndone++;
                if (t_done < 0) begin
                    t_done = c - 1; t_rdata = cpu_rdata; t_err = cpu_err;
                end
            end
            if (cpu_ready && t_done >= 0) t_ready = c - 1;
        end
        cpu_req = 1'b0; force_ack = 1'b0;
        check("txn_completed", 32'(t_ready >= 0), 32'd1);
    endtask

    initial begin
        int wl, rl, gap, nd, bad, sp_done, sp_strobe;
        rstz = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        resp_en = 1'b1; force_ack = 1'b0; ack_at = -1; pulse_at = -1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        check("rst_strobes", {30'd0, bus.regw, bus.regr}, 32'd0);
        check("rst_adr", bus.adr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_done_err", {30'd0, cpu_done, cpu_err}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        rstz = 1'b1;

        // write 'A'
        run_txn(1'b1, 32'h0001_3000, 32'h41, 30);
        check("wr_strobe_len", t_len, 32'd5);
        check("wr_done_edge", t_done, 32'd5);
        check("wr_ready_edge", t_ready, 32'd6);
        check("wr_ndone", t_ndone, 32'd1);
        check("wr_err", 32'(t_err), 32'd0);
        check("wr_bus_stable", t_bad, 32'd0);
        check("wr_rdata_kept", t_rdata, 32'd0);
        check("idle_adr_hold", bus.adr, 32'h0001_3000);
        check("idle_wdata_hold", bus.wdata, 32'h41);

        // read 0x100
        run_txn(1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 30);
        check("rd_strobe_len", t_len, 32'd5);
        check("rd_done_edge", t_done, 32'd5);
        check("rd_rdata", t_rdata, 32'h1234_5678);
        check("rd_regw_low", t_bad, 32'd0);
        check("rd_err", 32'(t_err), 32'd0);

        // read of another address, then a write must leave cpu_rdata alone
        run_txn(1'b0, 32'h0000_2000, 32'h0, 30);
        check("rd2_rdata", t_rdata, 32'h2000_BEEF);
        run_txn(1'b1, 32'h0000_0200, 32'h0000_0042, 30);
        check("wr2_rdata_held", cpu_rdata, 32'h2000_BEEF);

        // back-to-back with cpu_req held high
        wl = 0; rl = 0; gap = 0; nd = 0; bad = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0001_3000; cpu_wdata = 32'h55;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.regw) begin
                wl++;
                if (bus.adr !== 32'h0001_3000 || bus.wdata !== 32'h55) bad++;
                cpu_we = 1'b0; cpu_adr = 32'h0000_0100; cpu_wdata = 32'h0;
            end
            if (bus.regr) begin
                rl++;
                if (bus.adr !== 32'h0000_0100) bad++;
                cpu_req = 1'b0;
            end
            if (!bus.regw && !bus.regr && wl > 0 && rl == 0) gap++;
            if (cpu_done) nd++;
        end
        cpu_req = 1'b0;
        check("b2b_wr_len", wl, 32'd5);
        check("b2b_low_between", gap, 32'd2);
        check("b2b_rd_len", rl, 32'd5);
        check("b2b_ndone", nd, 32'd2);
        check("b2b_stable", bad, 32'd0);
        check("b2b_rdata", cpu_rdata, 32'h1234_5678);

        // busy request pulse during REQ, then spurious ack in IDLE
        pulse_at = 2;
        run_txn(1'b1, 32'h0000_0300, 32'h0000_0077, 30);
        pulse_at = -1;
        check("busy_ndone", t_ndone, 32'd1);
        check("busy_bus_stable", t_bad, 32'd0);
        check("busy_strobe_len", t_len, 32'd5);
        sp_done = 0; sp_strobe = 0;
        @(negedge clk); force_ack = 1'b1;
        @(negedge clk); force_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_done) sp_done++;
            if (bus.regw || bus.regr) sp_strobe++;
        end
        check("spur_no_done", sp_done, 32'd0);
        check("spur_no_strobe", sp_strobe, 32'd0);
        check("spur_ready", 32'(cpu_ready), 32'd1);

        // reset two cycles after accept
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0001_3000; cpu_wdata = 32'h42;
        @(negedge clk); cpu_req = 1'b0;
        @(negedge clk);
        check("pre_rst_regw", 32'(bus.regw), 32'd1);
        rstz = 1'b0;
        #1;
        check("rst_mid_strobes", {30'd0, bus.regw, bus.regr}, 32'd0);
        check("rst_mid_adr", bus.adr, 32'd0);
        check("rst_mid_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rstz = 1'b1;
        sp_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cpu_done) sp_done++;
        end
        check("rst_no_done", sp_done, 32'd0);
        run_txn(1'b1, 32'h0001_3000, 32'h43, 30);
        check("post_rst_len", t_len, 32'd5);
        check("post_rst_done_edge", t_done, 32'd5);

`ifdef PERI_MST_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_0100, 32'h0, 30);
        check("pre_to_rdata", t_rdata, 32'h1234_5678);
        resp_en = 1'b0;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 40);
        check("to_strobe_len", t_len, 32'd16);
        check("to_done_edge", t_done, 32'd16);
        check("to_err", 32'(t_err), 32'd1);
        check("to_rdata_zero", t_rdata, 32'd0);
        ack_at = 15;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 40);
        ack_at = -1;
        check("to_ack_len", t_len, 32'd16);
        check("to_ack_done_edge", t_done, 32'd16);
        check("to_ack_err", 32'(t_err), 32'd0);
        check("to_ack_rdata", t_rdata, 32'h1234_5678);
        run_txn(1'b1, 32'h0000_0400, 32'h0, 40);
        check("to_wr_err", 32'(t_err), 32'd1);
        check("to_wr_rdata_kept", t_rdata, 32'h1234_5678);
        resp_en = 1'b1;
`endif

        check("never_both_strobes", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
